tetris_game_ctrl: RTL and testbench

- Parametrised successor to the Tetris main game FSM: sequences GEN -> MOVE -> LAND -> CLEAR with proper start/done handshakes to each datapath.
- Adds pause, game-over detection, multi-row clear with row re-indexing, a gravity drop timer, and a line/level counter that speeds gravity up.
- Sits between the board/piece datapaths and the display/score logic.
- Single clock domain.

---
 rtl/tetris_game_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_tetris_game_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tetris_game_ctrl
// Purpose  : Main Tetris game sequencer (GEN/MOVE/LAND/CLEAR handshakes, pause,
//            game over, multi-row clear, gravity timer, line/level tracking).
// Revision : 1.0 - initial release
// ============================================================================
module tetris_game_ctrl #(
    parameter int ROWS            = 11,
    parameter int ROW_W           = 4,
    parameter int DROP_W          = 24,
    parameter int DROP_INIT       = 12500000,
    parameter int DROP_STEP       = 1000000,
    parameter int DROP_MIN        = 1500000,
    parameter int LINES_PER_LEVEL = 10,
    parameter int LINE_W          = 10,
    parameter int LVL_W           = 4
) (
    input  logic              clka,
    input  logic              restart,
    input  logic              start_btn,
    input  logic              pause_btn,
    input  logic              gen_done,
    input  logic              gen_blocked,
    input  logic              touched,
    input  logic              land_done,
    input  logic [ROWS-1:0]   full_rows,
    input  logic              clear_done,
    output logic [2:0]        state,
    output logic              start_gen,
    output logic              start_land,
    output logic              start_clear,
    output logic              move_en,
    output logic              drop_tick,
    output logic [ROW_W-1:0]  clear_row,
    output logic [LINE_W-1:0] lines,
    output logic [LVL_W-1:0]  level,
    output logic              game_over
);

    typedef enum logic [2:0] {
        S_NEWBOARD = 3'b000,
        S_GEN      = 3'b001,
        S_MOVE     = 3'b010,
        S_LAND     = 3'b011,
        S_CLEAR    = 3'b100,
        S_PAUSE    = 3'b101,
        S_OVER     = 3'b110
    } state_t;

    localparam int                c_floor_int = DROP_MIN + DROP_STEP;
    localparam int                c_lvl_int   = LINES_PER_LEVEL - 1;
    localparam logic [DROP_W-1:0] c_drop_init = DROP_INIT[DROP_W-1:0];
    localparam logic [DROP_W-1:0] c_drop_min  = DROP_MIN[DROP_W-1:0];
    localparam logic [DROP_W-1:0] c_drop_step = DROP_STEP[DROP_W-1:0];
    localparam logic [DROP_W:0]   c_floor     = c_floor_int[DROP_W:0];
    localparam logic [LINE_W-1:0] c_lvl_last  = c_lvl_int[LINE_W-1:0];

    state_t              r_state, w_next;
    logic [DROP_W-1:0]   r_drop_cnt, w_drop_cnt_next, r_interval, w_iv_dec;
    logic [ROWS-1:0]     r_mask, w_mask_next, w_mask_low, w_mask_shift;
    logic [LINE_W-1:0]   r_lines, r_lvl_cnt;
    logic [LVL_W-1:0]    r_level;
    logic [ROW_W-1:0]    r_clear_row;
    logic                r_start_gen, r_start_land, r_start_clear;
    logic                r_move_en, r_drop_tick, r_game_over;
    logic                w_new_game, w_land_accept, w_clear_step, w_tick;

    function automatic logic [ROW_W-1:0] low_index(input logic [ROWS-1:0] m);
        low_index = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (m[i]) low_index = ROW_W'(i);
        end
    endfunction

    // Isolate the lowest full row; rows above it fall by one once it is removed.
    assign w_mask_low   = r_mask & (~r_mask + ROWS'(1));
    assign w_mask_shift = (r_mask & ~w_mask_low) >> 1;
    assign w_iv_dec     = ({1'b0, r_interval} < c_floor) ? c_drop_min
                                                         : r_interval - c_drop_step;

    always_comb begin
        w_next          = r_state;
        w_new_game      = 1'b0;
        w_land_accept   = 1'b0;
        w_clear_step    = 1'b0;
        w_tick          = 1'b0;
        w_drop_cnt_next = r_drop_cnt;
        case (r_state)
            S_NEWBOARD: begin
                if (start_btn) begin
                    w_next     = S_GEN;
                    w_new_game = 1'b1;
                end
            end
            S_GEN: begin
                if (gen_done) begin
                    w_next          = gen_blocked ? S_OVER : S_MOVE;
                    w_drop_cnt_next = '0;
                end
            end
            S_MOVE: begin
                if (touched) begin
                    w_next = S_LAND;
                end else if (pause_btn) begin
                    w_next = S_PAUSE;
                end else if (r_drop_cnt == r_interval - DROP_W'(1)) begin
                    w_tick          = 1'b1;
                    w_drop_cnt_next = '0;
                end else begin
                    w_drop_cnt_next = r_drop_cnt + DROP_W'(1);
                end
            end
            S_PAUSE: begin
                if (pause_btn) w_next = S_MOVE;
            end
            S_LAND: begin
                if (land_done) begin
                    w_land_accept = 1'b1;
                    w_next        = (|full_rows) ? S_CLEAR : S_GEN;
                end
            end
            S_CLEAR: begin
                if (clear_done) begin
                    w_clear_step = 1'b1;
                    w_next       = (|w_mask_shift) ? S_CLEAR : S_GEN;
                end
            end
            S_OVER: begin
                if (start_btn) begin
                    w_next     = S_GEN;
                    w_new_game = 1'b1;
                end
            end
            default: w_next = S_NEWBOARD;
        endcase
    end

    always_comb begin
        w_mask_next = r_mask;
        if (w_land_accept)     w_mask_next = full_rows;
        else if (w_clear_step) w_mask_next = w_mask_shift;
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            r_state       <= S_NEWBOARD;
            r_drop_cnt    <= '0;
            r_interval    <= c_drop_init;
            r_mask        <= '0;
            r_lines       <= '0;
            r_lvl_cnt     <= '0;
            r_level       <= '0;
            r_clear_row   <= '0;
            r_start_gen   <= 1'b0;
            r_start_land  <= 1'b0;
            r_start_clear <= 1'b0;
            r_move_en     <= 1'b0;
            r_drop_tick   <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_drop_cnt    <= w_drop_cnt_next;
            r_mask        <= w_mask_next;
            r_clear_row   <= low_index(w_mask_next);
            r_start_gen   <= (w_next == S_GEN)  && (r_state != S_GEN);
            r_start_land  <= (w_next == S_LAND) && (r_state != S_LAND);
            r_start_clear <= (w_next == S_CLEAR) && ((r_state != S_CLEAR) || w_clear_step);
            r_move_en     <= (w_next == S_MOVE);
            r_drop_tick   <= w_tick;
            r_game_over   <= (w_next == S_OVER);
            if (w_new_game) begin
                r_lines    <= '0;
                r_lvl_cnt  <= '0;
                r_level    <= '0;
                r_interval <= c_drop_init;
            end else if (w_clear_step && !(&r_lines)) begin
                r_lines <= r_lines + LINE_W'(1);
                // Level-up fires on the clear that lands lines on a multiple.
                if (r_lvl_cnt == c_lvl_last) begin
                    r_lvl_cnt  <= '0;
                    r_interval <= w_iv_dec;
                    if (!(&r_level)) r_level <= r_level + LVL_W'(1);
                end else begin
                    r_lvl_cnt <= r_lvl_cnt + LINE_W'(1);
                end
            end
        end
    end

    assign state       = r_state;
    assign start_gen   = r_start_gen;
    assign start_land  = r_start_land;
    assign start_clear = r_start_clear;
    assign move_en     = r_move_en;
    assign drop_tick   = r_drop_tick;
    assign clear_row   = r_clear_row;
    assign lines       = r_lines;
    assign level       = r_level;
    assign game_over   = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_tetris_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tetris_game_ctrl
// Purpose  : Directed + random bench for tetris_game_ctrl against a rule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tetris_game_ctrl;

    localparam int ROWS = 11, ROW_W = 4, DROP_W = 8;
    localparam int DROP_INIT = 10, DROP_STEP = 4, DROP_MIN = 3, LPL = 2;
    localparam int LINE_W = 4, LVL_W = 2;
    localparam int LINE_MAX = 15, LVL_MAX = 3;
    localparam int NB = 0, GEN = 1, MOVE = 2, LAND = 3, CLEAR = 4, PAUSE = 5, OVER = 6;

    logic              clka = 1'b0;
    logic              restart = 1'b0, start_btn = 1'b0, pause_btn = 1'b0;
    logic              gen_done = 1'b0, gen_blocked = 1'b0, touched = 1'b0;
    logic              land_done = 1'b0, clear_done = 1'b0;
    logic [ROWS-1:0]   full_rows = '0;
    logic [2:0]        state;
    logic              start_gen, start_land, start_clear, move_en, drop_tick, game_over;
    logic [ROW_W-1:0]  clear_row;
    logic [LINE_W-1:0] lines;
    logic [LVL_W-1:0]  level;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int m_state = NB, m_cnt = 0, m_lines = 0;
    int m_rows[$];
    bit e_tick = 0, e_sg = 0, e_sl = 0, e_sc = 0;

    tetris_game_ctrl #(
        .ROWS(ROWS), .ROW_W(ROW_W), .DROP_W(DROP_W), .DROP_INIT(DROP_INIT),
        .DROP_STEP(DROP_STEP), .DROP_MIN(DROP_MIN), .LINES_PER_LEVEL(LPL),
        .LINE_W(LINE_W), .LVL_W(LVL_W)
    ) dut (
        .clka(clka), .restart(restart), .start_btn(start_btn), .pause_btn(pause_btn),
        .gen_done(gen_done), .gen_blocked(gen_blocked), .touched(touched),
        .land_done(land_done), .full_rows(full_rows), .clear_done(clear_done),
        .state(state), .start_gen(start_gen), .start_land(start_land),
        .start_clear(start_clear), .move_en(move_en), .drop_tick(drop_tick),
        .clear_row(clear_row), .lines(lines), .level(level), .game_over(game_over)
    );

    always #5 clka = ~clka;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time expired");
        $fatal(1, "watchdog");
    end

    function automatic int exp_level(input int l);
        return (l / LPL > LVL_MAX) ? LVL_MAX : l / LPL;
    endfunction

    function automatic int exp_interval(input int l);
        int iv = DROP_INIT - DROP_STEP * (l / LPL);
        return (iv < DROP_MIN) ? DROP_MIN : iv;
    endfunction

    task automatic model_step();
        int prev = m_state;
        e_tick = 0;
        e_sc   = 0;
        if (restart) begin
            m_state = NB; m_cnt = 0; m_lines = 0; m_rows.delete();
        end else begin
            case (m_state)
                NB, OVER: if (start_btn) begin m_state = GEN; m_lines = 0; end
                GEN: if (gen_done) begin
                    m_state = gen_blocked ? OVER : MOVE;
                    m_cnt = 0;
                end
                MOVE: begin
                    if (touched) m_state = LAND;
                    else if (pause_btn) m_state = PAUSE;
                    else begin
                        m_cnt++;
                        if (m_cnt == exp_interval(m_lines)) begin e_tick = 1; m_cnt = 0; end
                    end
                end
                PAUSE: if (pause_btn) m_state = MOVE;
                LAND: if (land_done) begin
                    for (int i = 0; i < ROWS; i++) if (full_rows[i]) m_rows.push_back(i);
                    m_state = (m_rows.size() != 0) ? CLEAR : GEN;
                end
                CLEAR: if (clear_done) begin
                    void'(m_rows.pop_front());
                    foreach (m_rows[i]) m_rows[i] = m_rows[i] - 1;
                    if (m_lines < LINE_MAX) m_lines++;
                    if (m_rows.size() != 0) e_sc = 1;
                    else m_state = GEN;
                end
                default: m_state = NB;
            endcase
        end
        e_sg = (m_state == GEN)   && (prev != GEN);
        e_sl = (m_state == LAND)  && (prev != LAND);
        if ((m_state == CLEAR) && (prev != CLEAR)) e_sc = 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        model_step();
        #1;
        chk("state", 32'(state), 32'(m_state));
        chk("start_gen", 32'(start_gen), 32'(e_sg));
        chk("start_land", 32'(start_land), 32'(e_sl));
        chk("start_clear", 32'(start_clear), 32'(e_sc));
        chk("move_en", 32'(move_en), 32'(m_state == MOVE));
        chk("drop_tick", 32'(drop_tick), 32'(e_tick));
        chk("game_over", 32'(game_over), 32'(m_state == OVER));
        chk("lines", 32'(lines), 32'(m_lines));
        chk("level", 32'(level), 32'(exp_level(m_lines)));
        if (m_state == CLEAR) chk("clear_row", 32'(clear_row), 32'(m_rows[0]));
        restart = 0; start_btn = 0; pause_btn = 0; gen_done = 0; gen_blocked = 0;
        touched = 0; land_done = 0; full_rows = '0; clear_done = 0;
    endtask

    task automatic run_until_cnt(input int t);
        int k = 0;
        while (m_cnt != t && k < 64) begin tick(); k++; end
        if (m_cnt != t) begin
            miscompares++;
            $display("FAIL wait_cnt: model counter %0d required %0d", m_cnt, t);
        end
    endtask

    initial begin
        // Reset and game start
        restart = 1; tick();
        restart = 1; tick();
        tick();
        start_btn = 1; tick();
        chk("start_gen_first", 32'(start_gen), 32'd1);
        tick();
        gen_done = 1; tick();
        repeat (24) tick();

        // touched coinciding with terminal count; empty landing
        run_until_cnt(exp_interval(m_lines) - 1);
        touched = 1; tick();
        chk("tick_suppressed", 32'(drop_tick), 32'd0);
        land_done = 1; full_rows = '0; tick();

        // Two-row clear with re-indexing
        gen_done = 1; tick();
        touched = 1; tick();
        land_done = 1; full_rows = 11'b00000000101; tick();
        chk("clear_row_a", 32'(clear_row), 32'd0);
        tick();
        clear_done = 1; tick();
        chk("clear_row_b", 32'(clear_row), 32'd1);
        clear_done = 1; tick();
        chk("lines_2", 32'(lines), 32'd2);
        chk("level_1", 32'(level), 32'd1);

        // Pause freezes gravity
        gen_done = 1; tick();
        run_until_cnt(2);
        pause_btn = 1; tick();
        repeat (20) begin start_btn = 1; tick(); end
        pause_btn = 1; tick();
        repeat (14) tick();

        // Second level-up floors the interval
        touched = 1; tick();
        land_done = 1; full_rows = 11'b00000000011; tick();
        clear_done = 1; tick();
        clear_done = 1; tick();
        chk("lines_4", 32'(lines), 32'd4);
        chk("level_2", 32'(level), 32'd2);
        gen_done = 1; tick();
        repeat (10) tick();

        // Full board clear saturates lines and level
        touched = 1; tick();
        land_done = 1; full_rows = 11'h7FF; tick();
        repeat (11) begin clear_done = 1; tick(); end
        chk("lines_sat", 32'(lines), 32'd15);
        chk("level_sat", 32'(level), 32'd3);
        gen_done = 1; tick();
        touched = 1; tick();
        land_done = 1; full_rows = 11'b1; tick();
        clear_done = 1; tick();
        chk("lines_hold", 32'(lines), 32'd15);

        // Game over ignores handshakes, then restart mid-clear
        gen_done = 1; gen_blocked = 1; tick();
        touched = 1; tick();
        land_done = 1; full_rows = 11'b1; tick();
        clear_done = 1; tick();
        gen_done = 1; pause_btn = 1; tick();
        chk("over_hold", 32'(state), 32'd6);
        start_btn = 1; tick();
        chk("lines_new_game", 32'(lines), 32'd0);
        gen_done = 1; tick();
        touched = 1; tick();
        land_done = 1; full_rows = 11'b110; tick();
        restart = 1; tick();
        chk("restart_state", 32'(state), 32'd0);
        tick();

        // Random stimulus against the model
        for (int n = 0; n < 4000; n++) begin
            restart     = ($urandom_range(0, 499) == 0);
            start_btn   = ($urandom_range(0, 9) == 0);
            pause_btn   = ($urandom_range(0, 14) == 0);
            gen_done    = ($urandom_range(0, 2) == 0);
            gen_blocked = ($urandom_range(0, 7) == 0);
            touched     = ($urandom_range(0, 11) == 0);
            land_done   = ($urandom_range(0, 2) == 0);
            full_rows   = ($urandom_range(0, 1) == 0) ? '0
                          : ROWS'($urandom & $urandom & $urandom);
            clear_done  = ($urandom_range(0, 1) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
